// File: rtl/mitch_log_mult_pipe.sv
// mitch_log_mult_pipe: 3-stage Mitchell log multiplier, valid/ready stream, async active-low reset
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready, x/y   operand pair handshake (N-bit operands)
//   out_valid/out_ready, p   product handshake (2N-bit approximate product)
module mitch_log_mult_pipe #(
  parameter int N = 16,
  parameter int W = 6,
  parameter bit SIGNED = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);
  localparam int KW = $clog2(N);
  localparam int GW = KW + W - 1;
  localparam int LW = KW + W;
  // {leading-one index, W-1 bits below it}; normalising left puts the leading one at N-1
  function automatic logic [GW-1:0] lg(input logic [N-1:0] a);
    logic [KW-1:0] k;
    logic [N-1:0] sh;
    k = '0;
    for (int i = 0; i < N; i++) if (a[i]) k = KW'(i);
    sh = a << (KW'(N - 1) - k);
    return {k, sh[N-2 -: W-1]};
  endfunction
  logic en;
  logic [N-1:0] ax, ay;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic z1_q, z1_d, s1_q, s1_d, z2_q, z2_d, s2_q, s2_d;
  logic [LW-1:0] l2_q, l2_d;
  logic [LW-W:0] k3;
  logic [W-2:0] f3;
  logic [2*N+W-1:0] t3;
  logic [2*N-1:0] mag, p_q, p_d;
  always_comb begin
    en   = ~v3_q | out_ready;
    ax   = (SIGNED && x[N-1]) ? -x : x;
    ay   = (SIGNED && y[N-1]) ? -y : y;
    v1_d = en ? in_valid : v1_q;
    v2_d = en ? v1_q : v2_q;
    v3_d = en ? v2_q : v3_q;
    gx_d = en ? lg(ax) : gx_q;
    gy_d = en ? lg(ay) : gy_q;
    z1_d = en ? (ax == '0 || ay == '0) : z1_q;
    s1_d = en ? ((SIGNED && x[N-1]) ^ (SIGNED && y[N-1])) : s1_q;
    l2_d = en ? LW'(gx_q) + LW'(gy_q) : l2_q;
    z2_d = en ? z1_q : z2_q;
    s2_d = en ? s1_q : s2_q;
    k3   = l2_q[LW-1:W-1];
    f3   = l2_q[W-2:0];
    // antilog: shift {1,f} by the integer part, then drop the W-1 fraction bits
    t3   = {{(2*N){1'b0}}, 1'b1, f3} << k3;
    mag  = t3[2*N+W-2:W-1];
    p_d  = en ? ((v2_q && !z2_q) ? (s2_q ? -mag : mag) : '0) : p_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      p_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      p_q  <= p_d;
    end
  end
  always_ff @(posedge clk) begin
    gx_q <= gx_d;
    gy_q <= gy_d;
    z1_q <= z1_d;
    s1_q <= s1_d;
    l2_q <= l2_d;
    z2_q <= z2_d;
    s2_q <= s2_d;
  end
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign p         = p_q;
endmodule

// File: tb/tb_mitch_log_mult_pipe.sv
module tb_mitch_log_mult_pipe;
  typedef struct {
    logic [31:0] e;
    int t;
    bit lat;
    logic [15:0] a;
    logic [15:0] b;
  } item_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [15:0] x = 0, y = 0;
  logic [31:0] p;
  logic u_in_valid = 0, u_in_ready, u_out_valid;
  logic [15:0] u_x = 0, u_y = 0;
  logic [31:0] u_p;
  logic [31:0] cur_exp = 0;
  bit cur_lat = 0;
  item_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_out = 0;
  bit stall_prev = 0;
  logic [31:0] p_prev = 0;
  mitch_log_mult_pipe #(.N(16), .W(6), .SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .p(p));
  mitch_log_mult_pipe #(.N(16), .W(6), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready), .x(u_x), .y(u_y),
    .out_valid(u_out_valid), .out_ready(1'b1), .p(u_p));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  function automatic longint lg(input longint a);
    int k = 0;
    longint r;
    for (int i = 0; i < 16; i++) if (a >= (64'sd1 << i)) k = i;
    r = a - (64'sd1 << k);
    return k * 32 + (k >= 5 ? r >>> (k - 5) : r <<< (5 - k));
  endfunction
  function automatic logic [31:0] mref(input logic [15:0] a, input logic [15:0] b, input bit sg);
    longint aa, bb, l, mag;
    bit ng;
    aa = (sg && a[15]) ? 65536 - longint'(a) : longint'(a);
    bb = (sg && b[15]) ? 65536 - longint'(b) : longint'(b);
    ng = sg && (a[15] ^ b[15]);
    if (aa == 0 || bb == 0) return 0;
    l = lg(aa) + lg(bb);
    mag = ((32 + (l % 32)) << (l / 32)) >> 5;
    return ng ? 32'(-mag) : 32'(mag);
  endfunction
  always @(negedge clk) begin
    if (!rst_n) stall_prev = 0;
    else begin
      if (out_valid && !out_ready) check("in_ready_stall", {63'd0, in_ready}, 64'd0);
      if (out_valid && !out_ready && stall_prev) check("p_hold", {32'd0, p}, {32'd0, p_prev});
      stall_prev = out_valid && !out_ready;
      p_prev = p;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", 64'd1, 64'd0);
        else begin
          item_t it;
          longint pr, ap;
          it = sb.pop_front();
          check("p", {32'd0, p}, {32'd0, it.e});
          if (it.lat) check("latency", 64'(cyc - it.t), 64'd3);
          pr = longint'($signed(it.a)) * longint'($signed(it.b));
          ap = longint'($signed(p));
          if (pr < 0) pr = -pr;
          if (ap < 0) ap = -ap;
          check("bound", {63'd0, ap <= pr}, 64'd1);
        end
        n_out++;
      end
      if (in_valid && in_ready) sb.push_back('{cur_exp, cyc, cur_lat, x, y});
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] e, input bit lat);
    int n = 0;
    in_valid = 1; x = a; y = b; cur_exp = e; cur_lat = lat;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_p", {32'd0, p}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    send(16'd3, 16'd3, 32'd8, 1);
    send(16'd5, 16'd7, 32'd32, 1);
    send(16'd1, 16'd1, 32'd1, 1);
    send(16'd100, -16'sd3, 32'hFFFFFEF0, 1);
    send(16'd0, -16'sd5, 32'd0, 1);
    send(-16'sd7, 16'd0, 32'd0, 1);
    send(16'h8000, 16'h8000, 32'h40000000, 1);
    send(16'h8000, 16'd1, 32'hFFFF8000, 1);
    drain();
    n0 = n_out;
    fork
      for (int i = 0; i < 6; i++) send(16'(i * 37 + 3), 16'(-(i * 11 + 2)), mref(16'(i * 37 + 3), 16'(-(i * 11 + 2)), 1), 0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("stream_count", 64'(n_out - n0), 64'd6);
    send(16'd3, 16'd3, 32'd8, 1);
    send(16'd5, 16'd7, 32'd32, 1);
    send(16'd1, 16'd1, 32'd1, 1);
    rst_n = 0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_p", {32'd0, p}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1;
    send(16'd5, 16'd7, 32'd32, 1);
    drain();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 10 == 0) a = 16'($urandom_range(0, 2));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x = a; y = b; cur_exp = mref(a, b, 1); cur_lat = 0;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    drain();
    u_x = 16'hFFFF; u_y = 16'hFFFF; u_in_valid = 1;
    @(posedge clk);
    #1 u_x = 16'hFFFF; u_y = 16'h0000;
    @(posedge clk);
    #1 u_in_valid = 0;
    @(posedge clk);
    #1;
    check("u_valid0", {63'd0, u_out_valid}, 64'd1);
    check("u_ffff_sq", {32'd0, u_p}, 64'hF8000000);
    @(posedge clk);
    #1;
    check("u_valid1", {63'd0, u_out_valid}, 64'd1);
    check("u_zero", {32'd0, u_p}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
